// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - round-robin, lockable, hold-limited arbiter for the shared data-memory port
// Optional performance counters are built when ARB_PERF_CNT_EN is defined.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic              m0_lock_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic              m1_lock_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              owner_o,
  output logic              timeout_o
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_gnt0_o,
  output logic [CNT_W-1:0]  perf_gnt1_o,
  output logic [CNT_W-1:0]  perf_conflict_o
`endif
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam bit HOLD_EN = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;

  logic              own_req, own_lock, own_we, oth_req;
  logic [HOLD_W-1:0] hold_stay;

  assign own_req  = owner_q ? m1_req_i  : m0_req_i;
  assign own_lock = owner_q ? m1_lock_i : m0_lock_i;
  assign own_we   = owner_q ? m1_we_i   : m0_we_i;
  assign oth_req  = owner_q ? m0_req_i  : m1_req_i;

  // Hold count only advances while the other master is actually waiting.
  assign hold_stay = !oth_req ? '0 : ((&hold_q) ? hold_q : hold_q + HOLD_W'(1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          state_d = OWN;
          owner_d = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;
          hold_d  = '0;
        end
      end
      OWN: begin
        if (HOLD_EN && oth_req && (hold_q == HOLD_LAST)) begin
          owner_d   = ~owner_q;
          last_d    = owner_q;
          hold_d    = '0;
          timeout_d = 1'b1;
        end else if (own_req && own_lock) begin
          hold_d = hold_stay;
        end else if (oth_req) begin
          owner_d = ~owner_q;
          last_d  = owner_q;
          hold_d  = '0;
        end else if (own_req) begin
          hold_d = hold_stay;
        end else begin
          state_d = IDLE;
          last_d  = owner_q;
          hold_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grants decode from registered state only; the write strobe is also
  // gated by reset so an aborted locked sequence cannot commit a write.
  always_comb begin
    m0_gnt_o    = 1'b0;
    m1_gnt_o    = 1'b0;
    m0_rdata_o  = '0;
    m1_rdata_o  = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    if (state_q == OWN) begin
      m0_gnt_o    = ~owner_q;
      m1_gnt_o    = owner_q;
      mem_addr_o  = owner_q ? m1_addr_i  : m0_addr_i;
      mem_wdata_o = owner_q ? m1_wdata_i : m0_wdata_i;
      mem_we_o    = own_req && own_we && rst_ni;
      if (owner_q) m1_rdata_o = mem_rdata_i;
      else         m0_rdata_o = mem_rdata_i;
    end
  end

  assign busy_o    = (state_q == OWN);
  assign owner_o   = owner_q;
  assign timeout_o = timeout_q;

`ifdef ARB_PERF_CNT_EN
  logic [CNT_W-1:0] gnt0_cnt, gnt1_cnt, conflict_cnt;
  logic             gnt0_hit, gnt1_hit, conflict_hit;

  assign gnt0_hit     = (state_q == OWN) && !owner_q && m0_req_i;
  assign gnt1_hit     = (state_q == OWN) &&  owner_q && m1_req_i;
  assign conflict_hit = ((state_q == OWN) && oth_req) ||
                        ((state_q == IDLE) && m0_req_i && m1_req_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      gnt0_cnt     <= '0;
      gnt1_cnt     <= '0;
      conflict_cnt <= '0;
    end else begin
      if (gnt0_hit && !(&gnt0_cnt))         gnt0_cnt     <= gnt0_cnt + CNT_W'(1);
      if (gnt1_hit && !(&gnt1_cnt))         gnt1_cnt     <= gnt1_cnt + CNT_W'(1);
      if (conflict_hit && !(&conflict_cnt)) conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

  assign perf_gnt0_o     = gnt0_cnt;
  assign perf_gnt1_o     = gnt1_cnt;
  assign perf_conflict_o = conflict_cnt;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed scoreboard bench for dmem_port_arbiter (MAX_HOLD=4)
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, busy, owner, timeout;
`ifdef ARB_PERF_CNT_EN
  logic [15:0] perf_gnt0, perf_gnt1, perf_conflict;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0] gnt;
    logic       we;
    logic       to;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem [256];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_lock_i(m0_lock),
    .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_lock_i(m1_lock),
    .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rdata_o(m1_rdata),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we), .mem_rdata_i(mem_rdata),
    .busy_o(busy), .owner_o(owner), .timeout_o(timeout)
`ifdef ARB_PERF_CNT_EN
    , .perf_gnt0_o(perf_gnt0), .perf_gnt1_o(perf_gnt1), .perf_conflict_o(perf_conflict)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] gnt, input logic we, input logic to);
    exp_t e;
    e.gnt = gnt;
    e.we  = we;
    e.to  = to;
    sb.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, "_gnt"}, {62'd0, m1_gnt, m0_gnt}, {62'd0, e.gnt});
    chk({tag, "_we"}, {63'd0, mem_we}, {63'd0, e.we});
    chk({tag, "_to"}, {63'd0, timeout}, {63'd0, e.to});
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h80] = 32'hCAFE0200;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_gnt", {62'd0, m1_gnt, m0_gnt}, 64'd0);
    chk("rst_we", {63'd0, mem_we}, 64'd0);
    chk("rst_addr", {32'd0, mem_addr}, 64'd0);
    chk("rst_wdata", {32'd0, mem_wdata}, 64'd0);
    chk("rst_rdata", {m1_rdata, m0_rdata}, 64'd0);
    chk("rst_busy", {62'd0, busy, owner}, 64'd0);
    chk("rst_to", {63'd0, timeout}, 64'd0);
`ifdef ARB_PERF_CNT_EN
    chk("rst_perf", {16'd0, perf_gnt0, perf_gnt1, perf_conflict}, 64'd0);
`endif

    // Single read by M0: grant one cycle after IDLE request
    tick();
    rst_n = 1'b1; m0_req = 1; m0_addr = 32'h40;
    push_exp(2'b00, 0, 0); sb_check("t1_c1");
    tick();
    push_exp(2'b01, 0, 0); sb_check("t1_c2");
    chk("t1_rdata0", {32'd0, m0_rdata}, 64'hDEADBEEF);
    chk("t1_rdata1", {32'd0, m1_rdata}, 64'd0);
    chk("t1_addr", {32'd0, mem_addr}, 64'h40);
    tick();
    m0_req = 0;
    push_exp(2'b01, 0, 0); sb_check("t1_c3");
    tick();
    push_exp(2'b00, 0, 0); sb_check("t1_c4");
    chk("t1_busy", {63'd0, busy}, 64'd0);

    // Tie from IDLE, then alternating grants without bubbles
    do_reset();
    rst_n = 1'b1;
    m0_req = 1; m0_addr = 32'h40; m1_req = 1; m1_addr = 32'h200;
    push_exp(2'b00, 0, 0); sb_check("t2_idle");
    for (int i = 0; i < 10; i++) begin
      tick();
      push_exp((i % 2 == 0) ? 2'b01 : 2'b10, 0, 0); sb_check($sformatf("t2_c%0d", i));
      chk($sformatf("t2_addr%0d", i), {32'd0, mem_addr}, (i % 2 == 0) ? 64'h40 : 64'h200);
    end
    tick();
    m0_req = 0; m1_req = 0;
    push_exp(2'b01, 0, 0); sb_check("t2_drop");
`ifdef ARB_PERF_CNT_EN
    chk("t2_perf_gnt0", {48'd0, perf_gnt0}, 64'd5);
    chk("t2_perf_gnt1", {48'd0, perf_gnt1}, 64'd5);
    chk("t2_perf_conf", {48'd0, perf_conflict}, 64'd11);
`endif
    tick();
    push_exp(2'b00, 0, 0); sb_check("t2_idle2");

    // Locked write pair by M0 while M1 waits
    do_reset();
    rst_n = 1'b1;
    m0_req = 1; m0_we = 1; m0_lock = 1; m0_addr = 32'h100; m0_wdata = 32'd5;
    m1_req = 1; m1_addr = 32'h200;
    push_exp(2'b00, 0, 0); sb_check("t3_idle");
    tick();
    push_exp(2'b01, 1, 0); sb_check("t3_w0");
    chk("t3_wdata0", {32'd0, mem_wdata}, 64'd5);
    tick();
    m0_addr = 32'h104; m0_wdata = 32'd9; m0_lock = 0;
    push_exp(2'b01, 1, 0); sb_check("t3_w1");
    chk("t3_addr1", {32'd0, mem_addr}, 64'h104);
    tick();
    m0_req = 0; m0_we = 0;
    push_exp(2'b10, 0, 0); sb_check("t3_m1");
    chk("t3_rdata1", {32'd0, m1_rdata}, 64'hCAFE0200);
    chk("t3_mem100", {32'd0, mem[8'h40]}, 64'd5);
    chk("t3_mem104", {32'd0, mem[8'h41]}, 64'd9);

    // Hold limit forces release after 4 owned cycles
    do_reset();
    rst_n = 1'b1;
    m0_req = 1; m0_lock = 1; m0_addr = 32'h40; m1_req = 1; m1_addr = 32'h200;
    push_exp(2'b00, 0, 0); sb_check("t4_idle");
    for (int i = 0; i < 4; i++) begin
      tick();
      push_exp(2'b01, 0, 0); sb_check($sformatf("t4_own%0d", i));
    end
    tick();
    push_exp(2'b10, 0, 1); sb_check("t4_forced");
    tick();
    push_exp(2'b01, 0, 0); sb_check("t4_back");

    // Reset while M1 holds a locked write sequence
    do_reset();
    rst_n = 1'b1;
    m1_req = 1; m1_we = 1; m1_lock = 1; m1_addr = 32'h300; m1_wdata = 32'h77;
    push_exp(2'b00, 0, 0); sb_check("t5_idle");
    tick();
    push_exp(2'b10, 1, 0); sb_check("t5_w");
    tick();
    rst_n = 1'b0; m1_addr = 32'h304; m1_wdata = 32'h88;
    push_exp(2'b10, 0, 0); sb_check("t5_rstcyc");
    tick();
    rst_n = 1'b1; m0_req = 1; m0_addr = 32'h40;
    push_exp(2'b00, 0, 0); sb_check("t5_after");
    chk("t5_busy", {63'd0, busy}, 64'd0);
    tick();
    push_exp(2'b01, 0, 0); sb_check("t5_tie");
    chk("t5_mem300", {32'd0, mem[8'hC0]}, 64'h77);
    chk("t5_mem304", {32'd0, mem[8'hC1]}, 64'd0);
    chk("t5_sb_empty", {32'd0, 32'(sb.size())}, 64'd0);

    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
